mem_bus_unit: RTL and testbench

//  Memory-access stage between the multicycle control FSM/datapath and external unified memory.

---
 rtl/mem_bus_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: memory-access stage between the multicycle control FSM and
// an external unified memory. Performs one read or write per request and
// holds the instruction register (fetches) and memory data register (data
// reads). req_done pulses for one cycle when the access finishes.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/write/is_data/addr/wdata   request from control, sampled in IDLE
//   req_done, req_err     one-cycle completion pulse, error qualifier
//   busy                  high in every state except IDLE
//   instr_out, data_out   instruction register, memory data register
//   bus_valid/we/addr/wdata, bus_ready   request channel to memory
//   bus_rvalid, bus_rdata read-data channel from memory
//   dbg_state             current FSM state, for observation only
//
// Handshake: a request transfers on any rising edge where bus_valid and
// bus_ready are both high; bus_addr/bus_we/bus_wdata stay stable while
// bus_valid waits for bus_ready. bus_valid may be withdrawn without a
// transfer (timeout abort). Read data transfers on a cycle with bus_rvalid
// high and is only accepted while waiting in RESP.
module mem_bus_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_is_data,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_done,
  output logic              req_err,
  output logic              busy,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The counter can reach TIMEOUT when a read is accepted on the last
  // allowed REQ cycle, so it needs room for TIMEOUT itself.
  localparam int               CNT_W   = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] NOP    = DATA_W'(32'h0000_0013);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic              isd_q, isd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    isd_d   = isd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_write;
          isd_d   = req_is_data;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: report the error without touching the bus.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A handshake on the limit cycle still counts as success.
        if (bus_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (we_q) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_RESP;
          end
        end else if (cnt_q >= CNT_LIM) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus_rvalid) begin
          if (isd_q) data_d  = bus_rdata;
          else       instr_d = bus_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q >= CNT_LIM) begin
          // Budget already spent: any cycle without data aborts.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      isd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      instr_q <= NOP;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      isd_q   <= isd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  assign req_done  = (state_q == S_DONE);
  assign req_err   = (state_q == S_DONE) && err_q;
  assign busy      = (state_q != S_IDLE);
  assign bus_valid = (state_q == S_REQ);
  assign bus_we    = (state_q == S_REQ) && we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign instr_out = instr_q;
  assign data_out  = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit: bench for mem_bus_unit. Main instance uses TIMEOUT=6;
// a second instance with TIMEOUT=4 covers the short-timeout scenario.
module tb_mem_bus_unit;

  localparam int T  = 6;
  localparam int T4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic        req_valid = 0, req_write = 0, req_is_data = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_done, req_err, busy;
  logic [31:0] instr_out, data_out;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready = 0, bus_rvalid = 0;
  logic [31:0] bus_rdata = 0;
  logic [1:0]  dbg_state;

  mem_bus_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_is_data(req_is_data),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .busy(busy),
    .instr_out(instr_out), .data_out(data_out),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- short-timeout DUT ----------------
  logic        r4_valid = 0, r4_write = 0, r4_isd = 0;
  logic [31:0] r4_addr = 0, r4_wdata = 0;
  logic        done4, err4, busy4;
  logic [31:0] instr4, data4;
  logic        bv4, bwe4;
  logic [31:0] baddr4, bwdata4;
  logic        ready4 = 0, rvalid4 = 0;
  logic [31:0] rdata4 = 0;
  logic [1:0]  dbg4;

  mem_bus_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(r4_valid), .req_write(r4_write), .req_is_data(r4_isd),
    .req_addr(r4_addr), .req_wdata(r4_wdata),
    .req_done(done4), .req_err(err4), .busy(busy4),
    .instr_out(instr4), .data_out(data4),
    .bus_valid(bv4), .bus_we(bwe4), .bus_addr(baddr4), .bus_wdata(bwdata4),
    .bus_ready(ready4), .bus_rvalid(rvalid4), .bus_rdata(rdata4),
    .dbg_state(dbg4)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] instr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] instr_m = 32'h0000_0013;
  logic [31:0] data_m  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome of one access from the memory's behaviour: dr = cycles bus_valid
  // waits before ready, dv = cycles between accept and rvalid. Cycle index 0
  // is the first bus_valid cycle; the access aborts on the first cycle with
  // index >= T-1 that neither handshakes nor delivers data.
  task automatic model(input logic we, input logic mis, input int dr, input int dv,
                       output logic err, output int lat);
    int abort_idx;
    if (mis) begin
      err = 1; lat = 1;
    end else if (dr >= T) begin
      err = 1; lat = T + 1;
    end else if (we) begin
      err = 0; lat = dr + 2;
    end else if (dv == 0 || dr + dv < T - 1) begin
      err = 0; lat = dr + dv + 3;
    end else begin
      abort_idx = (dr + 1 > T - 1) ? dr + 1 : T - 1;
      err = 1; lat = abort_idx + 2;
    end
  endtask

  // Monitor: pops one expectation per completion pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && req_done) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got req_done=1 expected no completion (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("req_err", req_err, e.err);
          check("instr_out", instr_out, e.instr);
          check("data_out", data_out, e.data);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called and returns at posedge+1. Drives one request and plays memory.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic isd,
                         input logic [31:0] wd, input int dr, input int dv,
                         input logic [31:0] rd, input bit stray);
    logic mis, err;
    int   lat, k;
    exp_t e;
    mis = (addr[1:0] != 2'b00);
    model(we, mis, dr, dv, err, lat);
    if (!err && !we) begin
      if (isd) data_m = rd;
      else     instr_m = rd;
    end
    e.cyc = cyc + lat; e.err = err; e.instr = instr_m; e.data = data_m;
    exp_q.push_back(e);
    req_addr = addr; req_write = we; req_is_data = isd; req_wdata = wd; req_valid = 1;
    @(posedge clk); #1;
    // Scramble the request inputs while busy; they must be ignored.
    req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
    if (mis) begin
      check("mis_no_bus_valid", bus_valid, 0);
      @(posedge clk); #1;
      req_valid = 0;
    end else begin
      k = 0;
      while (1) begin
        check("req_bus_valid", bus_valid, 1);
        check("req_bus_addr", bus_addr, addr);
        check("req_bus_we", bus_we, we);
        if (we) check("req_bus_wdata", bus_wdata, wd);
        bus_ready = (k == dr);
        @(posedge clk); #1;
        req_valid = 0; bus_ready = 0;
        if (k == dr || k == T - 1) break;
        k++;
      end
      if (!we && dr < T) begin
        for (int j = 0; j <= dv; j++) begin
          if (j == 0) check("resp_bus_valid_low", bus_valid, 0);
          bus_rvalid = (j == dv);
          bus_rdata  = (j == dv) ? rd : $urandom;
          @(posedge clk); #1;
          bus_rvalid = 0;
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("return_idle", busy, 0);
    if (stray) begin
      bus_rvalid = 1; bus_rdata = $urandom;
    end
    @(posedge clk); #1;
    bus_rvalid = 0;
  endtask

  // ---------------- short-timeout scenario ----------------
  task automatic run_t4();
    int n;
    r4_addr = 32'h8; r4_write = 0; r4_isd = 1; r4_valid = 1; ready4 = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      r4_valid = 0;
      if (bv4) n++;
      if (done4) break;
    end
    check("t4_done", done4, 1);
    check("t4_err", err4, 1);
    check("t4_valid_cycles", n, T4);
    check("t4_data_unchanged", data4, 0);
    @(posedge clk); #1;
    r4_addr = 32'h20; r4_isd = 0; r4_valid = 1;
    @(posedge clk); #1;
    r4_valid = 0; ready4 = 1;
    check("t4_fetch_valid", bv4, 1);
    @(posedge clk); #1;
    ready4 = 0; rvalid4 = 1; rdata4 = 32'h00A0_0113;
    @(posedge clk); #1;
    rvalid4 = 0;
    check("t4_fetch_done", done4, 1);
    check("t4_fetch_err", err4, 0);
    check("t4_fetch_instr", instr4, 32'h00A0_0113);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_done", req_done, 0);
    check("rst_req_err", req_err, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_instr", instr_out, 32'h0000_0013);
    check("rst_data", data_out, 0);
    reset_n = 1;
    @(posedge clk); #1;

    run_t4();

    // Directed cases: fetch, delayed data read, write + stray rvalid, misaligned.
    run_txn(32'h0,   0, 0, 0,            0, 0, 32'h0050_0093, 0);
    run_txn(32'h40,  0, 1, 0,            2, 2, 32'h1234_5678, 0);
    run_txn(32'h100, 1, 0, 32'hDEADBEEF, 0, 0, 0,             1);
    run_txn(32'h102, 0, 1, 0,            0, 0, 32'hFFFF_FFFF, 0);
    // Timeout boundaries.
    run_txn(32'h104, 1, 1, 32'h1,        T - 1, 0, 0,             0);
    run_txn(32'h108, 0, 1, 0,            T - 1, 0, 32'hA5A5_0001, 0);
    run_txn(32'h10C, 0, 0, 0,            T - 1, 1, 32'hA5A5_0002, 0);
    run_txn(32'h110, 0, 0, 0,            1, T - 3, 32'hA5A5_0003, 0);
    run_txn(32'h114, 0, 1, 0,            1, T - 2, 32'hA5A5_0004, 1);
    run_txn(32'h118, 1, 0, 32'h2,        T, 0, 0,             0);
    run_txn(32'h11C, 0, 0, 0,            T + 1, 0, 32'hA5A5_0005, 0);

    // Async reset while waiting in RESP.
    run_txn(32'h0, 0, 0, 0, 0, 0, 32'h0050_0093, 0);
    req_addr = 32'h4; req_write = 0; req_is_data = 0; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; bus_ready = 1;
    @(posedge clk); #1;
    bus_ready = 0;
    #3 reset_n = 0;
    #1;
    check("arst_bus_valid", bus_valid, 0);
    check("arst_instr", instr_out, 32'h0000_0013);
    check("arst_busy", busy, 0);
    check("arst_data", data_out, 0);
    instr_m = 32'h0000_0013; data_m = 32'h0;
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    run_txn(32'h8, 0, 0, 0, 0, 0, 32'h0010_0073, 0);

    // Randomized accesses.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run_txn(a, $urandom_range(0, 2) == 0, 1'($urandom), $urandom,
              $urandom_range(0, 7), $urandom_range(0, 6), $urandom,
              $urandom_range(0, 2) == 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
